// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with a one-entry holding buffer and run-time baud divisor.
// Frame: start, DATA_BITS data (LSB first), optional parity, STOP_BITS stop bits.
module uart_tx_param #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CNT_W-1:0]     count,
  input  logic [DATA_BITS-1:0] data_byte,
  input  logic                 tx_dv,
  output logic                 tx_ready,
  output logic                 serial_out,
  output logic                 tx_active,
  output logic                 tx_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
    $error("uart_tx_param: illegal parameter set DATA_BITS=%0d PARITY_MODE=%0d STOP_BITS=%0d",
           DATA_BITS, PARITY_MODE, STOP_BITS);
  end

  // Parity of a word: even = XOR of data bits, odd = its inverse.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (PARITY_MODE == 2) ? ~(^d) : (^d);
  endfunction

  state_t                 state_q, state_d;
  logic [DATA_BITS-1:0]   buf_q, buf_d;
  logic                   buf_vld_q, buf_vld_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       baud_q, baud_d;
  logic [3:0]             bit_q, bit_d;
  logic                   serial_q, serial_d;
  logic                   active_q, active_d;
  logic                   done_q, done_d;
  logic                   ready_q, ready_d;
  logic                   start_frame_s;
  logic                   bit_end_s;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      buf_q     <= '0;
      buf_vld_q <= 1'b0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      cnt_q     <= '0;
      baud_q    <= '0;
      bit_q     <= 4'd0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      buf_vld_q <= buf_vld_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      cnt_q     <= cnt_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      serial_q  <= serial_d;
      active_q  <= active_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state logic; serial_d always carries the level of the bit about to be driven.
  always_comb begin
    state_d       = state_q;
    buf_d         = buf_q;
    buf_vld_d     = buf_vld_q;
    shift_d       = shift_q;
    par_d         = par_q;
    cnt_d         = cnt_q;
    baud_d        = baud_q;
    bit_d         = bit_q;
    serial_d      = serial_q;
    active_d      = active_q;
    done_d        = 1'b0;
    start_frame_s = 1'b0;
    bit_end_s     = (baud_q == cnt_q);

    if (state_q != IDLE) begin
      if (bit_end_s) begin
        baud_d = '0;
      end else begin
        baud_d = baud_q + CNT_W'(1);
      end
    end else begin
      baud_d = '0;
    end

    case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        active_d = 1'b0;
        if (buf_vld_q) begin
          start_frame_s = 1'b1;
        end else begin
          start_frame_s = 1'b0;
        end
      end
      START: begin
        if (bit_end_s) begin
          state_d  = DATA;
          bit_d    = 4'd0;
          serial_d = shift_q[0];
          shift_d  = {1'b0, shift_q[DATA_BITS-1:1]};
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          if (bit_q != LAST_DATA) begin
            bit_d    = bit_q + 4'd1;
            serial_d = shift_q[0];
            shift_d  = {1'b0, shift_q[DATA_BITS-1:1]};
          end else if (PARITY_MODE != 0) begin
            state_d  = PARITY;
            serial_d = par_q;
          end else begin
            state_d  = STOP;
            bit_d    = 4'd0;
            serial_d = 1'b1;
          end
        end else begin
          state_d = DATA;
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          state_d  = STOP;
          bit_d    = 4'd0;
          serial_d = 1'b1;
        end else begin
          state_d = PARITY;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          if (bit_q == LAST_STOP) begin
            done_d = 1'b1;
            if (buf_vld_q) begin
              start_frame_s = 1'b1;
            end else begin
              state_d  = IDLE;
              serial_d = 1'b1;
              active_d = 1'b0;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
        active_d = 1'b0;
      end
    endcase

    // Unloading the buffer and latching the divisor happen together at frame start.
    if (start_frame_s) begin
      state_d   = START;
      shift_d   = buf_q;
      par_d     = parity_bit(buf_q);
      cnt_d     = count;
      buf_vld_d = 1'b0;
      baud_d    = '0;
      bit_d     = 4'd0;
      serial_d  = 1'b0;
      active_d  = 1'b1;
    end else begin
      cnt_d = cnt_q;
    end

    if (tx_dv && !buf_vld_q) begin
      buf_d     = data_byte;
      buf_vld_d = 1'b1;
    end else begin
      buf_d = buf_q;
    end

    ready_d = ~buf_vld_d;
  end

  assign tx_ready   = ready_q;
  assign serial_out = serial_q;
  assign tx_active  = active_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: three configurations (8E1, 5N1, 8O2) share clock/reset/count.
// Driver pushes expected frames on accept; per-instance monitors decode the line and compare.
module tb_uart_tx_param;

  typedef struct {
    logic [15:0] bits;
    int          n;
    int          cnt;
  } frame_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] count;
  logic [2:0] dv;
  logic [8:0] din [3];
  logic [2:0] rdy, ser, act, done;

  int vectors;
  int miscompares;
  int cyc;
  int acc_cyc;
  int ndone0, ndone1, ndone2;
  frame_t sb_q [3][$];

  uart_tx_param #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .CNT_W(8)) u_dut_8e1 (
    .clk(clk), .rst_n(rst_n), .count(count), .data_byte(din[0][7:0]), .tx_dv(dv[0]),
    .tx_ready(rdy[0]), .serial_out(ser[0]), .tx_active(act[0]), .tx_done(done[0]));

  uart_tx_param #(.DATA_BITS(5), .PARITY_MODE(0), .STOP_BITS(1), .CNT_W(8)) u_dut_5n1 (
    .clk(clk), .rst_n(rst_n), .count(count), .data_byte(din[1][4:0]), .tx_dv(dv[1]),
    .tx_ready(rdy[1]), .serial_out(ser[1]), .tx_active(act[1]), .tx_done(done[1]));

  uart_tx_param #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2), .CNT_W(8)) u_dut_8o2 (
    .clk(clk), .rst_n(rst_n), .count(count), .data_byte(din[2][7:0]), .tx_dv(dv[2]),
    .tx_ready(rdy[2]), .serial_out(ser[2]), .tx_active(act[2]), .tx_done(done[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done[0]) ndone0 <= ndone0 + 1;
    if (done[1]) ndone1 <= ndone1 + 1;
    if (done[2]) ndone2 <= ndone2 + 1;
  end

  task automatic chk(input string nm, input int u, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", nm, u, got, exp, $time);
    end
  endtask

  // Expected line levels for one frame; the parity argument is hand-computed per vector.
  function automatic frame_t build(input int u, input logic [8:0] d, input logic par);
    frame_t f;
    int db, pm, sbn;
    case (u)
      1:       begin db = 5; pm = 0; sbn = 1; end
      2:       begin db = 8; pm = 2; sbn = 2; end
      default: begin db = 8; pm = 1; sbn = 1; end
    endcase
    f.bits = 16'h0000;
    f.n = 1;
    for (int i = 0; i < db; i++) begin
      f.bits[f.n] = d[i];
      f.n++;
    end
    if (pm != 0) begin
      f.bits[f.n] = par;
      f.n++;
    end
    for (int s = 0; s < sbn; s++) begin
      f.bits[f.n] = 1'b1;
      f.n++;
    end
    f.cnt = int'(count);
    return f;
  endfunction

  task automatic send(input int u, input logic [8:0] d, input logic par, input bit hold);
    int k;
    frame_t e;
    @(negedge clk);
    din[u] = d;
    dv[u]  = 1'b1;
    k = 0;
    while (!rdy[u] && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (!rdy[u]) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout dut%0d: tx_ready never rose for data %0h", u, d);
      dv[u] = 1'b0;
      return;
    end
    e = build(u, d, par);
    sb_q[u].push_back(e);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!hold) dv[u] = 1'b0;
    chk("ready_low_after_accept", u, {31'b0, rdy[u]}, 32'd0);
  endtask

  task automatic wait_done(input int u, input int exp_lat);
    int k;
    k = 0;
    while (!done[u] && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("done_latency", u, done[u] ? (cyc - acc_cyc) : 32'hFFFF_FFFF, exp_lat);
  endtask

  task automatic wait_idle(input int u);
    int k;
    k = 0;
    while ((act[u] || !rdy[u] || sb_q[u].size() != 0) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", u, {31'b0, (k < 5000)}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_mon
    // Decode each frame on the line clock-by-clock against the queued expectation.
    initial begin
      frame_t e;
      bit ab;
      @(negedge clk);
      forever begin
        if (rst_n && ser[g] == 1'b0) begin
          if (sb_q[g].size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_frame dut%0d: start bit with empty scoreboard at t=%0t", g, $time);
            while (rst_n && ser[g] == 1'b0) @(negedge clk);
          end else begin
            e = sb_q[g].pop_front();
            ab = 1'b0;
            for (int b = 0; b < e.n && !ab; b++) begin
              for (int c = 0; c <= e.cnt && !ab; c++) begin
                if (!rst_n) begin
                  ab = 1'b1;
                end else begin
                  chk($sformatf("line_bit%0d", b), g, {31'b0, ser[g]}, {31'b0, e.bits[b]});
                  chk("active_in_frame", g, {31'b0, act[g]}, 32'd1);
                  if (b != 0 || c != 0) chk("no_early_done", g, {31'b0, done[g]}, 32'd0);
                  @(negedge clk);
                end
              end
            end
            if (!ab && rst_n) begin
              chk("done_pulse", g, {31'b0, done[g]}, 32'd1);
              if (sb_q[g].size() > 0) begin
                chk("b2b_start", g, {31'b0, ser[g]}, 32'd0);
                chk("b2b_active", g, {31'b0, act[g]}, 32'd1);
              end else begin
                chk("idle_line", g, {31'b0, ser[g]}, 32'd1);
                chk("idle_active", g, {31'b0, act[g]}, 32'd0);
              end
            end
          end
        end else begin
          @(negedge clk);
        end
      end
    end
  end

  initial begin
    int d0;
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    acc_cyc = 0;
    ndone0 = 0;
    ndone1 = 0;
    ndone2 = 0;
    rst_n = 1'b0;
    count = 8'd3;
    dv = 3'b000;
    for (int i = 0; i < 3; i++) din[i] = 9'h000;

    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk("rst_serial", u, {31'b0, ser[u]}, 32'd1);
      chk("rst_active", u, {31'b0, act[u]}, 32'd0);
      chk("rst_done", u, {31'b0, done[u]}, 32'd0);
      chk("rst_ready", u, {31'b0, rdy[u]}, 32'd1);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8E1, count=3, 0xAA: parity 0, 44-clock frame, done 45 clocks after accept.
    count = 8'd3;
    send(0, 9'h0AA, 1'b0, 1'b0);
    wait_done(0, 45);
    wait_idle(0);

    // Back-to-back with tx_dv held: 0x01 then 0x80, both even parity 1.
    count = 8'd1;
    d0 = ndone0;
    send(0, 9'h001, 1'b1, 1'b1);
    send(0, 9'h080, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk("ready_low_buffer_full", 0, {31'b0, rdy[0]}, 32'd0);
    wait_idle(0);
    chk("two_done_pulses", 0, ndone0 - d0, 32'd2);

    // count=0: one clock per bit, 0x7E has even parity 0.
    count = 8'd0;
    send(0, 9'h07E, 1'b0, 1'b0);
    wait_done(0, 12);
    wait_idle(0);

    // 5N1, count=0, 0x15: 0,1,0,1,0,1,1 over 7 clocks.
    send(1, 9'h015, 1'b0, 1'b0);
    wait_done(1, 8);
    wait_idle(1);

    // 8O2, count=1, 0xAA: odd parity 1, 12 bits x 2 = 24 clocks.
    count = 8'd1;
    send(2, 9'h0AA, 1'b1, 1'b0);
    wait_done(2, 25);
    wait_idle(2);

    // Reset in the middle of DATA.
    count = 8'd3;
    send(0, 9'h05A, 1'b0, 1'b0);
    repeat (11) @(negedge clk);
    chk("pre_reset_active", 0, {31'b0, act[0]}, 32'd1);
    d0 = ndone0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_serial_now", 0, {31'b0, ser[0]}, 32'd1);
    chk("reset_active_now", 0, {31'b0, act[0]}, 32'd0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("reset_no_done", 0, ndone0 - d0, 32'd0);
    chk("reset_ready_after", 0, {31'b0, rdy[0]}, 32'd1);
    chk("reset_line_idle", 0, {31'b0, ser[0]}, 32'd1);
    chk("reset_inactive", 0, {31'b0, act[0]}, 32'd0);

    // Divisor change mid-frame: 0xC3 keeps 4-clock bits, 0x0F then uses 8-clock bits.
    count = 8'd3;
    d0 = ndone0;
    send(0, 9'h0C3, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    count = 8'd7;
    send(0, 9'h00F, 1'b0, 1'b0);
    wait_idle(0);
    chk("count_change_dones", 0, ndone0 - d0, 32'd2);

    for (int u = 0; u < 3; u++) chk("scoreboard_empty", u, sb_q[u].size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
